// File: rtl/imc_wb_pkg.sv
// rtl/imc_wb_pkg.sv - shared types and widths for the IMC Wishbone initiator
package imc_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wb_state_e;

   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned SEL_W = 4;

   localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

   // Counter must reach both the ack timeout and the largest fixed-wait value.
   function automatic int unsigned cnt_width(input int unsigned timeout, input int unsigned wait_w);
      int unsigned wmax;
      int unsigned top;
      wmax = (32'd1 << wait_w) - 32'd1;
      top  = (timeout > wmax) ? timeout : wmax;
      return int'($clog2(top + 32'd1));
   endfunction

endpackage

// File: rtl/imc_wb_initiator.sv
// rtl/imc_wb_initiator.sv - Wishbone classic single-transfer master with valid/ready command and response streams
module imc_wb_initiator
   import imc_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned WAIT_W         = 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADR_W-1:0]  cmd_adr,
   input  logic [DAT_W-1:0]  cmd_dat,
   input  logic [SEL_W-1:0]  cmd_sel,
   input  logic              ack_mode,
   input  logic [WAIT_W-1:0] wait_cycles,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DAT_W-1:0]  rsp_dat,
   output logic              rsp_err,

   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [SEL_W-1:0]  wbm_sel_o,
   output logic [ADR_W-1:0]  wbm_adr_o,
   output logic [DAT_W-1:0]  wbm_dat_o,
   input  logic              wbm_ack_i,
   input  logic [DAT_W-1:0]  wbm_dat_i
);

   localparam int unsigned       CNT_W   = cnt_width(TIMEOUT_CYCLES, WAIT_W);
   localparam logic [CNT_W-1:0]  TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   wb_state_e         state_q;
   logic              ack_mode_q;
   logic [WAIT_W-1:0] wait_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [CNT_W-1:0]  wait_lim;
   logic              bus_done;
   logic              bus_err;
   logic [DAT_W-1:0]  bus_rdat;

   // A zero wait length still occupies the bus for one cycle.
   always_comb begin
      wait_lim = CNT_ONE;
      if (wait_q != '0) begin
         wait_lim = CNT_W'(wait_q);
      end
   end

   // Ack beats timeout when both land on the same edge.
   always_comb begin
      bus_done = 1'b0;
      bus_err  = 1'b0;
      if (ack_mode_q) begin
         if (wbm_ack_i) begin
            bus_done = 1'b1;
         end else if (cnt_q == TO_CNT) begin
            bus_done = 1'b1;
            bus_err  = 1'b1;
         end
      end else if (cnt_q == wait_lim) begin
         bus_done = 1'b1;
      end
      bus_rdat = (bus_err || wbm_we_o) ? '0 : wbm_dat_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ack_mode_q <= 1'b0;
         wait_q     <= '0;
         cnt_q      <= '0;
         cmd_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_dat    <= '0;
         rsp_err    <= 1'b0;
         wbm_cyc_o  <= 1'b0;
         wbm_stb_o  <= 1'b0;
         wbm_we_o   <= 1'b0;
         wbm_sel_o  <= '0;
         wbm_adr_o  <= '0;
         wbm_dat_o  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!cmd_ready) begin
                  cmd_ready <= 1'b1;
               end else if (cmd_valid) begin
                  cmd_ready  <= 1'b0;
                  wbm_cyc_o  <= 1'b1;
                  wbm_stb_o  <= 1'b1;
                  wbm_we_o   <= cmd_we;
                  wbm_sel_o  <= cmd_sel;
                  wbm_adr_o  <= cmd_adr;
                  wbm_dat_o  <= cmd_we ? cmd_dat : '0;
                  ack_mode_q <= ack_mode;
                  wait_q     <= wait_cycles;
                  cnt_q      <= CNT_ONE;
                  state_q    <= BUS;
               end
            end

            BUS: begin
               if (bus_done) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= bus_err;
                  rsp_dat   <= bus_rdat;
                  cnt_q     <= '0;
                  state_q   <= RESP;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state_q   <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/imc_wb_initiator.md
Name: imc_wb_initiator

Overview:
Wishbone classic single-transfer bus master; the initiator end of the Wishbone slave port of the RRAM in-memory-compute macro.
Converts a valid/ready command stream into one cyc/stb transaction at a time and returns read data or a status on a valid/ready response stream.
Used by on-chip sequencers and benches to program and read the IMC array.
Supports two completion modes: ack-terminated with a timeout, or fixed-wait for slaves that never drive ack.

Parameters:
TIMEOUT_CYCLES, 255, cycles stb may stay high in ack mode before abort with error; range 1..65535
WAIT_W, 8, width of wait_cycles

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_we  input  1  1 = write, 0 = read
cmd_adr  input  32  byte address
cmd_dat  input  32  write data
cmd_sel  input  4  byte lane select
ack_mode  input  1  1 = complete on wbm_ack_i; 0 = complete after wait_cycles; sampled at acceptance
wait_cycles  input  WAIT_W  fixed-wait length; sampled at acceptance
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_dat  output  32  read data; 0 for writes and errors
rsp_err  output  1  1 = timeout abort
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  write enable
wbm_sel_o  output  4  byte select
wbm_adr_o  output  32  address
wbm_dat_o  output  32  write data
wbm_ack_i  input  1  slave acknowledge
wbm_dat_i  input  32  slave read data

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, including cmd_ready; state IDLE; counter 0. Release is synchronous to clk; cmd_ready goes 1 on the first edge after release.
- FSM states: IDLE, BUS, RESP. All outputs come directly from registers; there is no combinational path from inputs to outputs.
- IDLE:
  - cmd_ready = 1.
  - On accept at edge T: latch we/adr/dat/sel/ack_mode/wait_cycles; cmd_ready drops; cyc and stb go high, and the bus fields are driven from edge T onward; go to BUS.
  - wbm_dat_o = cmd_dat for writes, 0 for reads.
- BUS:
  - cyc = stb = 1, bus fields stable; counter increments each cycle starting at 1 on the first BUS cycle.
  - Ack mode, wbm_ack_i sampled 1 at an edge: cyc and stb drop at that edge. rsp_dat = wbm_dat_i for reads, 0 for writes; rsp_err = 0; go to RESP.
  - Ack mode, no ack and counter == TIMEOUT_CYCLES: drop cyc and stb; rsp_err = 1, rsp_dat = 0; go to RESP.
  - Ack and timeout on the same edge: ack wins, rsp_err = 0.
  - Fixed-wait mode: ignore wbm_ack_i; complete when counter == max(wait_cycles, 1); read data sampled from wbm_dat_i at that edge; rsp_err = 0. wait_cycles = 0 behaves as 1.
  - Minimum bus occupancy is 1 cycle (ack on the first BUS edge).
- RESP:
  - rsp_valid = 1; rsp_dat and rsp_err held stable until the handshake.
  - On rsp_ready: rsp_valid drops, return to IDLE, and cmd_ready rises on that same edge.
  - rsp_ready may be held high permanently.
  - Throughput ceiling: one transaction per 3 cycles, plus wait/ack time.
- wbm_ack_i outside BUS is ignored.
- cmd_valid while cmd_ready = 0 is ignored; the requester must hold the command.
- Counter width is ceil(log2(max(TIMEOUT_CYCLES, 2^WAIT_W - 1) + 1)); it saturates and never wraps.
- Reset mid-transaction: cyc/stb drop immediately (asynchronously); any pending response is discarded.

Decomposition:
- Package imc_wb_pkg: FSM state enum (IDLE, BUS, RESP), Wishbone width constants (ADR_W = 32, DAT_W = 32, SEL_W = 4), default TIMEOUT_CYCLES.
- Single module. No sub-module; the counter is inline.

Test Plan:
1. Write, ack mode: cmd we=1, adr=0x3000_0004, dat=0xA5A5_0001, sel=0xF; slave acks on the 3rd BUS cycle -> wbm_adr_o=0x3000_0004 and wbm_dat_o=0xA5A5_0001 stable for 3 cycles, cyc low the next cycle, rsp_valid=1, rsp_err=0, rsp_dat=0.
2. Read, ack mode: slave returns 0x0000_0007 with ack on the 1st BUS cycle -> rsp_dat=0x0000_0007, rsp_err=0, stb high exactly 1 cycle.
3. Timeout: TIMEOUT_CYCLES=16, ack never asserted -> stb high exactly 16 cycles, rsp_err=1, rsp_dat=0; ack pulsed afterwards in IDLE is ignored.
4. Fixed wait: ack_mode=0, wait_cycles=5, read, wbm_dat_i=0x0000_0003 (ADC code), wbm_ack_i tied 0 -> stb high 5 cycles, rsp_dat=0x3, rsp_err=0. With wait_cycles=0 -> stb high 1 cycle.
5. Backpressure plus back-to-back: rsp_ready held low for 10 cycles with a second cmd_valid pending -> cmd_ready stays 0 and the response is stable; after rsp_ready, the second transaction's cyc rises the cycle after acceptance.
6. Async reset: rst_n low in the 2nd BUS cycle -> cyc/stb/rsp_valid 0 without a clock edge; after release, a new read completes normally.
